// File: rtl/cpu_ctrl_pkg.sv
// Shared control package: FSM state encoding, operand/ALU select codes,
// opcode/funct constants and the decoded control word.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned SRCB_W   = 3;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WR   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12,
        MD_START = 4'd13,
        MD_WAIT  = 4'd14
    } state_t;

    // Flavour of I-type ALU op, captured in DECODE so EXEC_I stays a pure state decode
    typedef enum logic [1:0] {
        IMM_ADD = 2'd0,
        IMM_AND = 2'd1,
        IMM_OR  = 2'd2
    } imm_kind_t;

    localparam logic [SRCB_W-1:0] ALUSRCB_REG      = 3'b000;
    localparam logic [SRCB_W-1:0] ALUSRCB_FOUR     = 3'b001;
    localparam logic [SRCB_W-1:0] ALUSRCB_SEXT     = 3'b010;
    localparam logic [SRCB_W-1:0] ALUSRCB_SEXT_SH2 = 3'b011;
    localparam logic [SRCB_W-1:0] ALUSRCB_ZEXT     = 3'b100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b101;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OPCODE_W-1:0] FUNCT_MULT = 6'h18;
    localparam logic [OPCODE_W-1:0] FUNCT_DIV  = 6'h1A;

    // Datapath control word produced every cycle by the state decoder
    typedef struct packed {
        logic               alu_src_a;
        logic [SRCB_W-1:0]  alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic               pc_write;
        logic               ir_write;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic [PCSRC_W-1:0] pc_source;
    } ctrl_word_t;

    // Quiescent control word: no strobes, PC+4 operand selected
    function automatic ctrl_word_t ctrl_idle();
        ctrl_word_t c;
        c           = '0;
        c.alu_src_b = ALUSRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        return c;
    endfunction

endpackage

// File: rtl/alu_src_decode.sv
// State -> datapath control word decoder for the multicycle sequencer.
// Optional feature macro: MULT_DIV_SEQ_EN (adds the md_start_c strobe).
module alu_src_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [PCSRC_W-1:0] TRAP_ADDR_SEL = 2'b11
) (
    input  logic       enable,
    input  state_t     state,
    input  imm_kind_t  imm_kind,
    input  logic       zero,
    input  logic       mem_ready,
`ifdef MULT_DIV_SEQ_EN
    output logic       md_start_c,
`endif
    output ctrl_word_t ctrl_c
);

    // Moore decode of the registered state; held idle while reset is asserted
    always_comb begin
        ctrl_c = ctrl_idle();
`ifdef MULT_DIV_SEQ_EN
        md_start_c = 1'b0;
`endif
        if (enable) begin
            case (state)
                FETCH: begin
                    ctrl_c.mem_read = 1'b1;
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = mem_ready;
                end
                DECODE: begin
                    ctrl_c.alu_src_b = ALUSRCB_SEXT_SH2;
                end
                EXEC_R: begin
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = ALUSRCB_REG;
                    ctrl_c.alu_op    = ALUOP_FUNCT;
                end
                WB_R: begin
                    ctrl_c.reg_dst   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                end
                EXEC_I: begin
                    ctrl_c.alu_src_a = 1'b1;
                    case (imm_kind)
                        IMM_AND: begin
                            ctrl_c.alu_src_b = ALUSRCB_ZEXT;
                            ctrl_c.alu_op    = ALUOP_AND;
                        end
                        IMM_OR: begin
                            ctrl_c.alu_src_b = ALUSRCB_ZEXT;
                            ctrl_c.alu_op    = ALUOP_OR;
                        end
                        default: begin
                            ctrl_c.alu_src_b = ALUSRCB_SEXT;
                            ctrl_c.alu_op    = ALUOP_ADD;
                        end
                    endcase
                end
                WB_I: begin
                    ctrl_c.reg_write = 1'b1;
                end
                MEM_ADDR: begin
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = ALUSRCB_SEXT;
                end
                MEM_RD: begin
                    ctrl_c.mem_read = 1'b1;
                end
                MEM_WR: begin
                    ctrl_c.mem_write = 1'b1;
                end
                WB_MEM: begin
                    ctrl_c.mem_to_reg = 1'b1;
                    ctrl_c.reg_write  = 1'b1;
                end
                BRANCH: begin
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = ALUSRCB_REG;
                    ctrl_c.alu_op    = ALUOP_SUB;
                    ctrl_c.pc_source = PCSRC_ALUOUT;
                    ctrl_c.pc_write  = zero;
                end
                JUMP: begin
                    ctrl_c.pc_source = PCSRC_JUMP;
                    ctrl_c.pc_write  = 1'b1;
                end
                TRAP: begin
                    ctrl_c.pc_source = TRAP_ADDR_SEL;
                    ctrl_c.pc_write  = 1'b1;
                end
`ifdef MULT_DIV_SEQ_EN
                MD_START: begin
                    md_start_c = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_src_sequencer.sv
// Multicycle CPU control FSM: fetch/decode/execute/writeback sequencing,
// memory-ready wait with timeout trap, illegal-opcode trap.
// Optional feature macro: MULT_DIV_SEQ_EN (mult/div handshake via md_start/md_done).
module alu_src_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [PCSRC_W-1:0] TRAP_ADDR_SEL = 2'b11,
    parameter int unsigned        MEM_TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OPCODE_W-1:0] funct,
    input  logic                zero,
    input  logic                mem_ready,
`ifdef MULT_DIV_SEQ_EN
    input  logic                md_done,
    output logic                md_start,
`endif
    output logic                alu_src_a,
    output logic [SRCB_W-1:0]   alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic [PCSRC_W-1:0]  pc_source,
    output logic                mem_err,
    output logic [STATE_W-1:0]  state_dbg
);

    localparam int unsigned      CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit               TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    imm_kind_t        imm_kind_q, imm_kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_set;
    logic             waiting;
    logic             timeout_c;
    ctrl_word_t       ctrl_c;

`ifndef MULT_DIV_SEQ_EN
    // funct only steers the mult/div dispatch
    logic unused_funct;
    assign unused_funct = ^funct;
`endif

    // Last allowed wait cycle has been reached
    assign timeout_c = TO_EN && (cnt_q == TO_LAST);

    // State, wait counter, I-type flavour and sticky error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            imm_kind_q <= IMM_ADD;
            cnt_q      <= '0;
            mem_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            imm_kind_q <= imm_kind_d;
            cnt_q      <= cnt_d;
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next-state, opcode dispatch and memory-wait timeout
    always_comb begin
        state_d    = state_q;
        imm_kind_d = imm_kind_q;
        cnt_d      = '0;
        err_set    = 1'b0;
        waiting    = 1'b0;

        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
                else           waiting = 1'b1;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
`ifdef MULT_DIV_SEQ_EN
                        if (funct == FUNCT_MULT || funct == FUNCT_DIV) state_d = MD_START;
                        else                                           state_d = EXEC_R;
`else
                        state_d = EXEC_R;
`endif
                    end
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI: begin
                        state_d    = EXEC_I;
                        imm_kind_d = IMM_ADD;
                    end
                    OP_ANDI: begin
                        state_d    = EXEC_I;
                        imm_kind_d = IMM_AND;
                    end
                    OP_ORI: begin
                        state_d    = EXEC_I;
                        imm_kind_d = IMM_OR;
                    end
                    OP_J:         state_d = JUMP;
                    default:      state_d = TRAP;
                endcase
            end
            EXEC_R:   state_d = WB_R;
            WB_R:     state_d = FETCH;
            EXEC_I:   state_d = WB_I;
            WB_I:     state_d = FETCH;
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready) state_d = WB_MEM;
                else           waiting = 1'b1;
            end
            MEM_WR: begin
                if (mem_ready) state_d = FETCH;
                else           waiting = 1'b1;
            end
            WB_MEM:   state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            TRAP:     state_d = FETCH;
`ifdef MULT_DIV_SEQ_EN
            MD_START: state_d = MD_WAIT;
            MD_WAIT: begin
                if (md_done) state_d = FETCH;
            end
`endif
            default:  state_d = FETCH;
        endcase

        // Ready was checked first, so a same-cycle ready beats the timeout
        if (waiting) begin
            if (timeout_c) begin
                state_d = TRAP;
                err_set = 1'b1;
            end else if (TO_EN) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Control word decode; gated by reset so strobes drop as soon as it asserts
    alu_src_decode #(
        .TRAP_ADDR_SEL (TRAP_ADDR_SEL)
    ) u_decode (
        .enable     (reset),
        .state      (state_q),
        .imm_kind   (imm_kind_q),
        .zero       (zero),
        .mem_ready  (mem_ready),
`ifdef MULT_DIV_SEQ_EN
        .md_start_c (md_start),
`endif
        .ctrl_c     (ctrl_c)
    );

    assign alu_src_a  = ctrl_c.alu_src_a;
    assign alu_src_b  = ctrl_c.alu_src_b;
    assign alu_op     = ctrl_c.alu_op;
    assign pc_write   = ctrl_c.pc_write;
    assign ir_write   = ctrl_c.ir_write;
    assign mem_read   = ctrl_c.mem_read;
    assign mem_write  = ctrl_c.mem_write;
    assign reg_write  = ctrl_c.reg_write;
    assign reg_dst    = ctrl_c.reg_dst;
    assign mem_to_reg = ctrl_c.mem_to_reg;
    assign pc_source  = ctrl_c.pc_source;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Directed bench for alu_src_sequencer (honours MULT_DIV_SEQ_EN when defined).
module tb_alu_src_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       alu_src_a;
    logic [2:0] alu_src_b, alu_op;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] pc_source;
    logic       mem_err;
    logic [3:0] state_dbg;
`ifdef MULT_DIV_SEQ_EN
    logic       md_done, md_start;
`endif

    int   total = 0;
    int   bad   = 0;
    logic exp_err;

    always #5 clk = ~clk;

    alu_src_sequencer #(
        .TRAP_ADDR_SEL (2'b11),
        .MEM_TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
`ifdef MULT_DIV_SEQ_EN
        .md_done    (md_done),
        .md_start   (md_start),
`endif
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_source  (pc_source),
        .mem_err    (mem_err),
        .state_dbg  (state_dbg)
    );

    localparam logic [5:0] V_RT   = 6'h00;
    localparam logic [5:0] V_J    = 6'h02;
    localparam logic [5:0] V_BEQ  = 6'h04;
    localparam logic [5:0] V_ADDI = 6'h08;
    localparam logic [5:0] V_ORI  = 6'h0D;
    localparam logic [5:0] V_LW   = 6'h23;
    localparam logic [5:0] V_SW   = 6'h2B;
    localparam logic [5:0] V_BAD  = 6'h3F;

    // {a, b[2:0], op[2:0], pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem2reg, pcsrc[1:0]}
    localparam logic [15:0] W_IDLE    = {1'b0, 3'b001, 3'b000, 7'b0000000, 2'b00};
    localparam logic [15:0] W_FETCH_R = {1'b0, 3'b001, 3'b000, 7'b1110000, 2'b00};
    localparam logic [15:0] W_FETCH_W = {1'b0, 3'b001, 3'b000, 7'b0110000, 2'b00};
    localparam logic [15:0] W_DEC     = {1'b0, 3'b011, 3'b000, 7'b0000000, 2'b00};
    localparam logic [15:0] W_EXR     = {1'b1, 3'b000, 3'b010, 7'b0000000, 2'b00};
    localparam logic [15:0] W_WBR     = {1'b0, 3'b001, 3'b000, 7'b0000110, 2'b00};
    localparam logic [15:0] W_ADDI    = {1'b1, 3'b010, 3'b000, 7'b0000000, 2'b00};
    localparam logic [15:0] W_ORI     = {1'b1, 3'b100, 3'b100, 7'b0000000, 2'b00};
    localparam logic [15:0] W_WBI     = {1'b0, 3'b001, 3'b000, 7'b0000100, 2'b00};
    localparam logic [15:0] W_MADDR   = {1'b1, 3'b010, 3'b000, 7'b0000000, 2'b00};
    localparam logic [15:0] W_MRD     = {1'b0, 3'b001, 3'b000, 7'b0010000, 2'b00};
    localparam logic [15:0] W_MWR     = {1'b0, 3'b001, 3'b000, 7'b0001000, 2'b00};
    localparam logic [15:0] W_WBM     = {1'b0, 3'b001, 3'b000, 7'b0000101, 2'b00};
    localparam logic [15:0] W_BR1     = {1'b1, 3'b000, 3'b001, 7'b1000000, 2'b01};
    localparam logic [15:0] W_BR0     = {1'b1, 3'b000, 3'b001, 7'b0000000, 2'b01};
    localparam logic [15:0] W_JMP     = {1'b0, 3'b001, 3'b000, 7'b1000000, 2'b10};
    localparam logic [15:0] W_TRAP    = {1'b0, 3'b001, 3'b000, 7'b1000000, 2'b11};

    function automatic logic [15:0] cw_now();
        return {alu_src_a, alu_src_b, alu_op, pc_write, ir_write, mem_read,
                mem_write, reg_write, reg_dst, mem_to_reg, pc_source};
    endfunction

    // Count one comparison and report it on mismatch
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check state, control word and mem_err
    task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic z, input state_t st, input logic [15:0] w);
        @(negedge clk);
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        zero      = z;
        #1;
        chk({tag, ".st"},  32'(state_dbg), 32'(st));
        chk({tag, ".cw"},  32'(cw_now()),  32'(w));
        chk({tag, ".err"}, 32'(mem_err),   32'(exp_err));
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = '0;
        funct     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        exp_err   = 1'b0;
`ifdef MULT_DIV_SEQ_EN
        md_done   = 1'b0;
`endif

        // Reset holds strobes low even with mem_ready high
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("rst.st",  32'(state_dbg), 32'(FETCH));
        chk("rst.cw",  32'(cw_now()),  32'(W_IDLE));
        chk("rst.err", 32'(mem_err),   32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b1;

        // add
        cyc("add.f", V_RT, 6'h20, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("add.d", V_RT, 6'h20, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("add.x", V_RT, 6'h20, 1'b1, 1'b0, EXEC_R, W_EXR);
        cyc("add.w", V_RT, 6'h20, 1'b1, 1'b0, WB_R,   W_WBR);

        // ori
        cyc("ori.f", V_ORI, 6'h00, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("ori.d", V_ORI, 6'h00, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("ori.x", V_ORI, 6'h00, 1'b1, 1'b0, EXEC_I, W_ORI);
        cyc("ori.w", V_ORI, 6'h00, 1'b1, 1'b0, WB_I,   W_WBI);

        // addi
        cyc("addi.f", V_ADDI, 6'h00, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("addi.d", V_ADDI, 6'h00, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("addi.x", V_ADDI, 6'h00, 1'b1, 1'b0, EXEC_I, W_ADDI);
        cyc("addi.w", V_ADDI, 6'h00, 1'b1, 1'b0, WB_I,   W_WBI);

        // beq taken, then not taken
        cyc("beq1.f", V_BEQ, 6'h00, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("beq1.d", V_BEQ, 6'h00, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("beq1.b", V_BEQ, 6'h00, 1'b1, 1'b1, BRANCH, W_BR1);
        cyc("beq0.f", V_BEQ, 6'h00, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("beq0.d", V_BEQ, 6'h00, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("beq0.b", V_BEQ, 6'h00, 1'b1, 1'b0, BRANCH, W_BR0);

        // jump
        cyc("j.f", V_J, 6'h00, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("j.d", V_J, 6'h00, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("j.j", V_J, 6'h00, 1'b1, 1'b0, JUMP,   W_JMP);

        // lw with five not-ready cycles in MEM_RD
        cyc("lw.f", V_LW, 6'h00, 1'b1, 1'b0, FETCH,    W_FETCH_R);
        cyc("lw.d", V_LW, 6'h00, 1'b1, 1'b0, DECODE,   W_DEC);
        cyc("lw.a", V_LW, 6'h00, 1'b1, 1'b0, MEM_ADDR, W_MADDR);
        for (int i = 0; i < 5; i++) begin
            cyc("lw.wait", V_LW, 6'h00, 1'b0, 1'b0, MEM_RD, W_MRD);
        end
        cyc("lw.rd", V_LW, 6'h00, 1'b1, 1'b0, MEM_RD, W_MRD);
        cyc("lw.wb", V_LW, 6'h00, 1'b1, 1'b0, WB_MEM, W_WBM);

        // sw interrupted by reset while waiting in MEM_WR
        cyc("sw.f", V_SW, 6'h00, 1'b1, 1'b0, FETCH,    W_FETCH_R);
        cyc("sw.d", V_SW, 6'h00, 1'b1, 1'b0, DECODE,   W_DEC);
        cyc("sw.a", V_SW, 6'h00, 1'b1, 1'b0, MEM_ADDR, W_MADDR);
        cyc("sw.w", V_SW, 6'h00, 1'b0, 1'b0, MEM_WR,   W_MWR);
        #2;
        reset = 1'b0;
        #1;
        chk("swrst.st", 32'(state_dbg), 32'(FETCH));
        chk("swrst.cw", 32'(cw_now()),  32'(W_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // illegal opcode traps
        cyc("ill.f", V_BAD, 6'h00, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("ill.d", V_BAD, 6'h00, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("ill.t", V_BAD, 6'h00, 1'b1, 1'b0, TRAP,   W_TRAP);

        // mult funct under R-type
        cyc("mul.f", V_RT, 6'h18, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("mul.d", V_RT, 6'h18, 1'b1, 1'b0, DECODE, W_DEC);
`ifdef MULT_DIV_SEQ_EN
        cyc("mul.s", V_RT, 6'h18, 1'b1, 1'b0, MD_START, W_IDLE);
        chk("mul.start1", 32'(md_start), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc("mul.wait", V_RT, 6'h18, 1'b1, 1'b0, MD_WAIT, W_IDLE);
            chk("mul.start0", 32'(md_start), 32'd0);
        end
        cyc("mul.done", V_RT, 6'h18, 1'b1, 1'b0, MD_WAIT, W_IDLE);
        md_done = 1'b1;
        @(posedge clk);
        #1;
        md_done = 1'b0;
`else
        cyc("mul.x", V_RT, 6'h18, 1'b1, 1'b0, EXEC_R, W_EXR);
        cyc("mul.w", V_RT, 6'h18, 1'b1, 1'b0, WB_R,   W_WBR);
`endif

        // ready arriving on the timeout cycle wins
        for (int i = 0; i < 15; i++) begin
            cyc("rw.wait", V_RT, 6'h20, 1'b0, 1'b0, FETCH, W_FETCH_W);
        end
        cyc("rw.f", V_RT, 6'h20, 1'b1, 1'b0, FETCH,  W_FETCH_R);
        cyc("rw.d", V_RT, 6'h20, 1'b1, 1'b0, DECODE, W_DEC);
        cyc("rw.x", V_RT, 6'h20, 1'b1, 1'b0, EXEC_R, W_EXR);
        cyc("rw.w", V_RT, 6'h20, 1'b1, 1'b0, WB_R,   W_WBR);

        // memory never ready: timeout after 16 cycles, sticky error, trap
        for (int i = 0; i < 16; i++) begin
            cyc("to.wait", V_RT, 6'h20, 1'b0, 1'b0, FETCH, W_FETCH_W);
        end
        exp_err = 1'b1;
        cyc("to.trap", V_RT, 6'h20, 1'b0, 1'b0, TRAP,  W_TRAP);
        cyc("to.keep", V_RT, 6'h20, 1'b0, 1'b0, FETCH, W_FETCH_W);

        // only reset clears mem_err
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("clr.err", 32'(mem_err),   32'd0);
        chk("clr.st",  32'(state_dbg), 32'(FETCH));
        chk("clr.cw",  32'(cw_now()),  32'(W_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
